// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse init sequencer (reset, BAT, ID, enable with timeouts/retries)
// and 3-byte movement packet assembler with a debug state code.
module ps2_mouse_ctrl #(
    parameter int CLK_HZ     = 27_000_000,
    parameter int PWRUP_CYC  = 2_700_000,
    parameter int ACK_TO_CYC = 675_000,
    parameter int BAT_TO_CYC = 27_000_000,
    parameter int PKT_TO_CYC = 54_000,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tx_req,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_err,
    output logic       init_done,
    output logic       error,
    output logic       activity,
    output logic       pkt_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [3:0] debug_state
);
    typedef enum logic [3:0] {
        PWRUP     = 4'd0,
        SEND_RST  = 4'd1,
        WAIT_ACK1 = 4'd2,
        WAIT_BAT  = 4'd3,
        WAIT_ID   = 4'd4,
        SEND_EN   = 4'd5,
        WAIT_ACK2 = 4'd6,
        STREAM    = 4'd7,
        ERROR     = 4'd8
    } state_t;

    state_t      state, state_n;
    logic [31:0] timer, to_last;
    logic [7:0]  retry_cnt, status, xbyte, exp_byte;
    logic [1:0]  idx, idx_n;
    logic        fail, clr, take, discard, is_send;

    if (CLK_HZ < 1 || MAX_RETRY < 1) begin : g_param_check
        $error("ps2_mouse_ctrl: CLK_HZ and MAX_RETRY must be positive");
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        fail     = 1'b0;
        is_send  = state == SEND_RST || state == SEND_EN;
        exp_byte = state == WAIT_BAT ? 8'hAA : state == WAIT_ID ? 8'h00 : 8'hFA;
        to_last  = 32'(state == WAIT_BAT ? BAT_TO_CYC - 1 : ACK_TO_CYC - 1);
        discard  = state == STREAM && rx_valid && idx == 2'd0 && !rx_byte[3];
        take     = state == STREAM && rx_valid && !rx_err && !discard;
        case (state)
            PWRUP: if (timer == 32'(PWRUP_CYC - 1)) state_n = SEND_RST;
            SEND_RST, SEND_EN: begin
                if (tx_done) state_n = state == SEND_RST ? WAIT_ACK1 : WAIT_ACK2;
                else if (tx_err) fail = 1'b1;
            end
            WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
                // a byte arriving on the timeout cycle is judged on its value
                if (rx_valid && !rx_err && rx_byte == exp_byte)
                    state_n = state == WAIT_ACK1 ? WAIT_BAT : state == WAIT_BAT ? WAIT_ID :
                              state == WAIT_ID ? SEND_EN : STREAM;
                else if (rx_valid || rx_err || timer == to_last) fail = 1'b1;
            end
            STREAM: begin
                if (rx_err || (idx != 2'd0 && !take && timer == 32'(PKT_TO_CYC - 1))) idx_n = 2'd0;
                else if (take) idx_n = idx == 2'd2 ? 2'd0 : idx + 2'd1;
            end
            default: ;
        endcase
        if (fail) state_n = retry_cnt + 8'd1 == 8'(MAX_RETRY) ? ERROR : SEND_RST;
        clr = state_n != state || fail || take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PWRUP;
            timer       <= '0;
            retry_cnt   <= '0;
            idx         <= '0;
            status      <= '0;
            xbyte       <= '0;
            tx_req      <= 1'b0;
            tx_byte     <= '0;
            init_done   <= 1'b0;
            error       <= 1'b0;
            activity    <= 1'b0;
            pkt_valid   <= 1'b0;
            buttons     <= '0;
            dx          <= '0;
            dy          <= '0;
            debug_state <= '0;
        end else begin
            state       <= state_n;
            timer       <= clr ? '0 : timer + 32'd1;
            idx         <= idx_n;
            if (fail) retry_cnt <= retry_cnt + 8'd1;
            if (take && idx == 2'd0) status <= rx_byte;
            if (take && idx == 2'd1) xbyte <= rx_byte;
            if (take && idx == 2'd2) begin
                buttons <= status[2:0];
                dx      <= {status[4], xbyte};
                dy      <= {status[5], rx_byte};
            end
            pkt_valid   <= take && idx == 2'd2;
            activity    <= rx_valid && !discard;
            tx_req      <= is_send && !tx_done && !tx_err;
            tx_byte     <= state == SEND_EN ? 8'hF4 : state == SEND_RST ? 8'hFF : tx_byte;
            init_done   <= state_n == STREAM;
            error       <= state_n == ERROR;
            debug_state <= state_n;
        end
    end
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb_ps2_mouse_ctrl: directed bench for the PS/2 mouse sequencer with hand-computed expectations.
module tb_ps2_mouse_ctrl;
    logic       clk = 1'b0, rst_n = 1'b1, tx_done = 1'b0, tx_err = 1'b0, rx_valid = 1'b0, rx_err = 1'b0;
    logic [7:0] rx_byte = 8'h00, tx_byte;
    logic       tx_req, init_done, error, activity, pkt_valid;
    logic [2:0] buttons;
    logic [8:0] dx, dy;
    logic [3:0] debug_state;
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ps2_mouse_ctrl #(.PWRUP_CYC(100), .ACK_TO_CYC(500), .BAT_TO_CYC(2000), .PKT_TO_CYC(300), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_byte(tx_byte), .tx_done(tx_done), .tx_err(tx_err),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_err(rx_err), .init_done(init_done), .error(error),
        .activity(activity), .pkt_valid(pkt_valid), .buttons(buttons), .dx(dx), .dy(dy), .debug_state(debug_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic txdone();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!tx_req && n < 700) begin
            tick();
            n++;
        end
    endtask

    task automatic init_stream();
        int n;
        wait_req(n);
        txdone();
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        wait_req(n);
        txdone();
        rx(8'hFA);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
        n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL rst_tx_byte: got %h want 00", tx_byte); end
        n_cmp++; if (debug_state !== 4'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", debug_state); end
        n_cmp++; if ({init_done, error, activity, pkt_valid} !== 4'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {init_done, error, activity, pkt_valid}); end
        n_cmp++; if ({buttons, dx, dy} !== 21'b0) begin n_bad++; $display("FAIL rst_pkt: got %h want 0", {buttons, dx, dy}); end
    endtask

    task automatic test_nominal_init();
        int n;
        rst_n = 1'b1;
        wait_req(n);
        n_cmp++; if (n < 100 || n > 102) begin n_bad++; $display("FAIL nom_pwrup_delay: got %0d want 100..102", n); end
        n_cmp++; if (tx_byte !== 8'hFF) begin n_bad++; $display("FAIL nom_cmd_ff: got %h want ff", tx_byte); end
        n_cmp++; if (debug_state !== 4'd1) begin n_bad++; $display("FAIL nom_state1: got %0d want 1", debug_state); end
        txdone();
        n_cmp++; if (debug_state !== 4'd2) begin n_bad++; $display("FAIL nom_state2: got %0d want 2", debug_state); end
        n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL nom_req_drop: got %b want 0", tx_req); end
        rx(8'hFA);
        n_cmp++; if (debug_state !== 4'd3) begin n_bad++; $display("FAIL nom_state3: got %0d want 3", debug_state); end
        n_cmp++; if (activity !== 1'b1) begin n_bad++; $display("FAIL nom_activity: got %b want 1", activity); end
        rx(8'hAA);
        n_cmp++; if (debug_state !== 4'd4) begin n_bad++; $display("FAIL nom_state4: got %0d want 4", debug_state); end
        rx(8'h00);
        n_cmp++; if (debug_state !== 4'd5) begin n_bad++; $display("FAIL nom_state5: got %0d want 5", debug_state); end
        wait_req(n);
        n_cmp++; if (n > 2 || tx_byte !== 8'hF4) begin n_bad++; $display("FAIL nom_cmd_f4: got %h after %0d want f4 within 2", tx_byte, n); end
        txdone();
        n_cmp++; if (debug_state !== 4'd6) begin n_bad++; $display("FAIL nom_state6: got %0d want 6", debug_state); end
        rx(8'hFA);
        n_cmp++; if (debug_state !== 4'd7) begin n_bad++; $display("FAIL nom_state7: got %0d want 7", debug_state); end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL nom_init_done: got %b want 1", init_done); end
    endtask

    task automatic test_packets();
        rx(8'h09);
        n_cmp++; if (activity !== 1'b1 || pkt_valid !== 1'b0) begin n_bad++; $display("FAIL pkt_byte0: act %b pv %b want 1 0", activity, pkt_valid); end
        rx(8'h05);
        rx(8'hFD);
        n_cmp++; if (pkt_valid !== 1'b1) begin n_bad++; $display("FAIL pkt1_valid: got %b want 1", pkt_valid); end
        n_cmp++; if ({buttons, dx, dy} !== {3'b001, 9'h005, 9'h0FD}) begin n_bad++; $display("FAIL pkt1_data: got %b %h %h want 001 005 0fd", buttons, dx, dy); end
        tick();
        n_cmp++; if (pkt_valid !== 1'b0 || dx !== 9'h005) begin n_bad++; $display("FAIL pkt1_hold: pv %b dx %h want 0 005", pkt_valid, dx); end
        rx(8'h18);
        rx(8'hF6);
        rx(8'h08);
        n_cmp++; if (pkt_valid !== 1'b1) begin n_bad++; $display("FAIL pkt2_valid: got %b want 1", pkt_valid); end
        n_cmp++; if ({buttons, dx, dy} !== {3'b000, 9'h1F6, 9'h008}) begin n_bad++; $display("FAIL pkt2_data: got %b %h %h want 000 1f6 008", buttons, dx, dy); end
    endtask

    task automatic test_resync();
        rx(8'h05);
        n_cmp++; if (activity !== 1'b0 || debug_state !== 4'd7) begin n_bad++; $display("FAIL resync_drop: act %b st %0d want 0 7", activity, debug_state); end
        rx(8'h09);
        rx(8'h01);
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL resync_early: got %b want 0", pkt_valid); end
        rx(8'h02);
        n_cmp++; if (pkt_valid !== 1'b1 || {buttons, dx, dy} !== {3'b001, 9'h001, 9'h002}) begin n_bad++; $display("FAIL resync_pkt: pv %b %b %h %h want 1 001 001 002", pkt_valid, buttons, dx, dy); end
    endtask

    task automatic test_pkt_timeout();
        int pv = 0;
        rx(8'h09);
        rx(8'h05);
        for (int i = 0; i < 310; i++) begin
            tick();
            if (pkt_valid) pv++;
        end
        n_cmp++; if (pv !== 0) begin n_bad++; $display("FAIL pto_no_pkt: got %0d pulses want 0", pv); end
        rx(8'h08);
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL pto_dropped: got %b want 0", pkt_valid); end
        rx(8'h01);
        rx(8'h01);
        n_cmp++; if (pkt_valid !== 1'b1 || {buttons, dx, dy} !== {3'b000, 9'h001, 9'h001}) begin n_bad++; $display("FAIL pto_pkt: pv %b %b %h %h want 1 000 001 001", pkt_valid, buttons, dx, dy); end
    endtask

    task automatic test_retry();
        int n;
        do_reset();
        wait_req(n);
        txdone();
        wait_req(n);
        n_cmp++; if (n < 500 || n > 502) begin n_bad++; $display("FAIL retry_delay: got %0d want 500..502", n); end
        n_cmp++; if (tx_byte !== 8'hFF || debug_state !== 4'd1) begin n_bad++; $display("FAIL retry_resend: byte %h st %0d want ff 1", tx_byte, debug_state); end
    endtask

    task automatic test_error();
        int n, reqs = 0;
        txdone();
        wait_req(n);
        n_cmp++; if (n < 500 || n > 502 || error !== 1'b0) begin n_bad++; $display("FAIL err_retry2: delay %0d err %b want 500..502 0", n, error); end
        txdone();
        for (int i = 0; i < 700; i++) begin
            tick();
            if (tx_req) reqs++;
        end
        n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL err_no_tx: got %0d req cycles want 0", reqs); end
        n_cmp++; if (error !== 1'b1 || debug_state !== 4'd8) begin n_bad++; $display("FAIL err_state: err %b st %0d want 1 8", error, debug_state); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL err_init_done: got %b want 0", init_done); end
    endtask

    task automatic test_bat_fc();
        int n;
        do_reset();
        wait_req(n);
        txdone();
        rx(8'hFA);
        rx(8'hFC);
        n_cmp++; if (debug_state !== 4'd1) begin n_bad++; $display("FAIL fc_state: got %0d want 1", debug_state); end
        wait_req(n);
        n_cmp++; if (n !== 1 || tx_byte !== 8'hFF) begin n_bad++; $display("FAIL fc_resend: byte %h after %0d want ff after 1", tx_byte, n); end
    endtask

    task automatic test_tx_err_en();
        int n;
        txdone();
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        wait_req(n);
        n_cmp++; if (tx_byte !== 8'hF4) begin n_bad++; $display("FAIL txerr_f4: got %h want f4", tx_byte); end
        tx_err = 1'b1;
        tick();
        tx_err = 1'b0;
        n_cmp++; if (debug_state !== 4'd1 || tx_req !== 1'b0) begin n_bad++; $display("FAIL txerr_fail: st %0d req %b want 1 0", debug_state, tx_req); end
        tick();
        n_cmp++; if (tx_req !== 1'b1 || tx_byte !== 8'hFF) begin n_bad++; $display("FAIL txerr_resend: req %b byte %h want 1 ff", tx_req, tx_byte); end
        init_stream();
        n_cmp++; if (init_done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL txerr_recover: init %b err %b want 1 0", init_done, error); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        wait_req(n);
        txdone();
        rx(8'hFA);
        n_cmp++; if (debug_state !== 4'd3) begin n_bad++; $display("FAIL rmid_bat: got %0d want 3", debug_state); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({tx_req, tx_byte, init_done, error, activity, pkt_valid, buttons, dx, dy, debug_state} !== 38'b0) begin n_bad++; $display("FAIL rmid_async: got %h want 0", {tx_req, tx_byte, init_done, error, activity, pkt_valid, buttons, dx, dy, debug_state}); end
        tick();
        tick();
        rst_n = 1'b1;
        wait_req(n);
        n_cmp++; if (n < 100 || n > 102 || tx_byte !== 8'hFF) begin n_bad++; $display("FAIL rmid_resend: delay %0d byte %h want 100..102 ff", n, tx_byte); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req_drop: got %b want 0", tx_req); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal_init();
        test_packets();
        test_resync();
        test_pkt_timeout();
        test_retry();
        test_error();
        test_bat_fc();
        test_tx_err_en();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
